// File: rtl/serial_pattern_tx_pkg.sv
// ---------------------------------------------------------------------------
// serial_pattern_tx_pkg
//   Shared definitions for the serial pattern transmitter.
//   - tx_state_t : FSM state codes (3-bit), also exposed on state_dbg.
//   - BIT_HI/BIT_LO : line levels.
//       They use the same polarity as found/notfound in the sequence
//       detectors, so a bench can wire serial_out straight into them.
// ---------------------------------------------------------------------------
package serial_pattern_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_GAP   = 3'd2,
        ST_DONE  = 3'd3
    } tx_state_t;

    localparam logic BIT_HI = 1'b1;
    localparam logic BIT_LO = 1'b0;

endpackage

// File: rtl/tx_shift_reg.sv
// ---------------------------------------------------------------------------
// tx_shift_reg
//   Holds the latched pattern copy and the working shift register.
//   The first bit of every repetition is driven onto the line by the caller
//   (from din on load, from first_bit on reload). The working register
//   therefore always holds the bits that remain *after* the one on the line.
// Ports
//   clk, reset  : clock, async active-low reset
//   load        : latch din as the pattern; working reg <= din << 1
//   reload      : working reg <= latched pattern << 1 (start of a repetition)
//   shift       : working reg <<= 1
//   din         : pattern input
//   msb         : next bit to transmit (working reg MSB)
//   first_bit   : MSB of the latched pattern
// ---------------------------------------------------------------------------
module tx_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             reload,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb,
    output logic             first_bit
);

    logic [WIDTH-1:0] pat;
    logic [WIDTH-1:0] shreg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat   <= '0;
            shreg <= '0;
        end else if (load) begin
            pat   <= din;
            shreg <= din << 1;
        end else if (reload) begin
            shreg <= pat << 1;
        end else if (shift) begin
            shreg <= shreg << 1;
        end
    end

    assign msb       = shreg[WIDTH-1];
    assign first_bit = pat[WIDTH-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// ---------------------------------------------------------------------------
// serial_pattern_tx
//   Latches a WIDTH-bit pattern on start and shifts it out MSB-first, one
//   bit per clock, (repeat_n+1) times. Optionally GAP idle cycles separate
//   the repetitions. done pulses for one cycle after the last bit.
//
// Handshake (start/ready):
//   A start is accepted on a rising edge where ready=1. A start seen while
//   ready=0 is dropped, not queued. ready goes low on the accepting edge and
//   returns high on the edge that enters IDLE.
//
// Ports
//   clk          : clock, rising edge
//   reset        : asynchronous, active-low reset
//   start        : begin a frame (sampled while ready=1)
//   pattern      : WIDTH-bit pattern, latched at start
//   repeat_n     : extra repetitions (total = repeat_n+1), latched at start
//   abort        : cancel an active frame (SHIFT/GAP) without a done pulse
//   ready        : block is idle and accepts start
//   serial_out   : transmitted bit, 0 whenever serial_valid=0
//   serial_valid : serial_out carries a pattern bit
//   done         : one-cycle pulse after the last bit of a frame
//   state_dbg    : current FSM state code
// ---------------------------------------------------------------------------
module serial_pattern_tx
    import serial_pattern_tx_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic             abort,
    output logic             ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             done,
    output logic [2:0]       state_dbg
);

    localparam int              BIT_W    = $clog2(WIDTH);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
    localparam bit              HAS_GAP  = (GAP > 0);
    localparam int              GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

    tx_state_t        state;
    logic [BIT_W-1:0] bit_cnt;   // bits still to send after the one on the line
    logic [CNT_W-1:0] rep_cnt;   // repetitions still to start
    logic [GAP_W-1:0] gap_cnt;   // gap cycles remaining after the current one

    logic sr_load;
    logic sr_reload;
    logic sr_shift;
    logic sr_msb;
    logic sr_first;

    // The last bit of a repetition with more repetitions to follow.
    logic last_bit_more;
    assign last_bit_more = (state == ST_SHIFT) && (bit_cnt == '0) && (rep_cnt != '0);

    assign sr_load   = (state == ST_IDLE) && start;
    assign sr_shift  = (state == ST_SHIFT) && !abort && (bit_cnt != '0);
    // Reload at the edge where the first bit of the next repetition goes out:
    // straight from SHIFT when there is no gap, else at the end of GAP.
    assign sr_reload = !abort &&
                       ((last_bit_more && !HAS_GAP) ||
                        ((state == ST_GAP) && (gap_cnt == '0)));

    tx_shift_reg #(.WIDTH(WIDTH)) u_shreg (
        .clk       (clk),
        .reset     (reset),
        .load      (sr_load),
        .reload    (sr_reload),
        .shift     (sr_shift),
        .din       (pattern),
        .msb       (sr_msb),
        .first_bit (sr_first)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            rep_cnt      <= '0;
            gap_cnt      <= '0;
            ready        <= 1'b1;
            serial_out   <= BIT_LO;
            serial_valid <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // start beats abort here: abort only cancels an active frame
                    if (start) begin
                        state        <= ST_SHIFT;
                        ready        <= 1'b0;
                        rep_cnt      <= repeat_n;
                        bit_cnt      <= BIT_LAST;
                        serial_out   <= pattern[WIDTH-1];
                        serial_valid <= 1'b1;
                    end
                end

                ST_SHIFT: begin
                    if (abort) begin
                        state        <= ST_IDLE;
                        ready        <= 1'b1;
                        serial_out   <= BIT_LO;
                        serial_valid <= 1'b0;
                    end else if (bit_cnt != '0) begin
                        bit_cnt    <= bit_cnt - 1'b1;
                        serial_out <= sr_msb;
                    end else if (rep_cnt != '0) begin
                        rep_cnt <= rep_cnt - 1'b1;
                        if (HAS_GAP) begin
                            state        <= ST_GAP;
                            gap_cnt      <= GAP_LAST;
                            serial_out   <= BIT_LO;
                            serial_valid <= 1'b0;
                        end else begin
                            // No bubble: first bit of the next repetition.
                            bit_cnt    <= BIT_LAST;
                            serial_out <= sr_first;
                        end
                    end else begin
                        state        <= ST_DONE;
                        serial_out   <= BIT_LO;
                        serial_valid <= 1'b0;
                        done         <= 1'b1;
                    end
                end

                ST_GAP: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        ready <= 1'b1;
                    end else if (gap_cnt == '0) begin
                        state        <= ST_SHIFT;
                        bit_cnt      <= BIT_LAST;
                        serial_out   <= sr_first;
                        serial_valid <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                end

                default: begin
                    state        <= ST_IDLE;
                    ready        <= 1'b1;
                    serial_out   <= BIT_LO;
                    serial_valid <= 1'b0;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule
